// File: rtl/irq_encoder8to3_pkg.sv
// ---------------------------------------------------------------------------
// irq_enc_pkg
// Shared constants and types for the irq_encoder8to3 block.
//   N_SRC           : number of request sources (fixed at 8)
//   CODE_W          : width of the presented source index (3)
//   irq_enc_state_t : handshake state (IDLE = nothing presented,
//                     PRESENT = out_code/out_valid held for the consumer)
// ---------------------------------------------------------------------------
package irq_enc_pkg;

    localparam int N_SRC  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } irq_enc_state_t;

endpackage : irq_enc_pkg

// File: rtl/irq_encoder8to3_if.sv
// ---------------------------------------------------------------------------
// irq_encoder8to3_if
// Groups the request inputs and the code/handshake outputs of the encoder.
//   req       : level request lines, a 0->1 transition is an event
//   mask      : per-source enable, 1 = selectable (only with IRQ_ENC_MASK_EN)
//   out_valid : out_code holds a pending source
//   out_ready : consumer accepts out_code when out_valid & out_ready
//   out_code  : index of the presented source
//   pending   : latched pending bits, unmasked view
//   overrun   : one-cycle pulse, an edge hit an already-pending source
// Modports: master = encoder side, slave = requester/consumer side.
// Optional feature macro: IRQ_ENC_MASK_EN (adds the mask signal).
// ---------------------------------------------------------------------------
interface irq_encoder8to3_if;
    import irq_enc_pkg::*;

    logic [N_SRC-1:0]  req;
`ifdef IRQ_ENC_MASK_EN
    logic [N_SRC-1:0]  mask;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [N_SRC-1:0]  pending;
    logic              overrun;

`ifdef IRQ_ENC_MASK_EN
    modport master (
        input  req, mask, out_ready,
        output out_valid, out_code, pending, overrun
    );
    modport slave (
        output req, mask, out_ready,
        input  out_valid, out_code, pending, overrun
    );
`else
    modport master (
        input  req, out_ready,
        output out_valid, out_code, pending, overrun
    );
    modport slave (
        output req, out_ready,
        input  out_valid, out_code, pending, overrun
    );
`endif

endinterface : irq_encoder8to3_if

// File: rtl/irq_encoder8to3_prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
// Combinational find-first-set over an 8-bit vector; bit 0 has the highest
// priority.
//   vec : input vector
//   idx : index of the lowest set bit (0 when vec is empty)
//   any : at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_enc8
    import irq_enc_pkg::*;
(
    input  logic [N_SRC-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    always_comb begin
        // NOTE: idx gets a value before the loop so every path assigns it;
        // otherwise an empty vec would infer a latch.
        idx = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule : prio_enc8

// File: rtl/irq_encoder8to3.sv
// ---------------------------------------------------------------------------
// irq_encoder8to3
// Sequential 8-to-3 priority encoder. Rising edges on req are latched into
// a pending register; the lowest-index selectable pending source is
// presented as out_code over a valid/ready handshake. Once presented, the
// code is held until accepted, even if a higher-priority edge arrives.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : irq_encoder8to3_if.master (req, mask, out_valid, out_ready,
//           out_code, pending, overrun)
// Optional feature macro: IRQ_ENC_MASK_EN -- candidate set is pending & mask
// instead of pending. Masked sources still latch pending and overrun.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module irq_encoder8to3
    import irq_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    irq_encoder8to3_if.master bus
);

    logic [N_SRC-1:0]  req_q;
    logic [N_SRC-1:0]  pending_q;
    logic [N_SRC-1:0]  edge_v;
    logic [N_SRC-1:0]  clear_v;
    logic [N_SRC-1:0]  cand;
    logic              accept;
    logic              overrun_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic [CODE_W-1:0] win_idx;
    logic              win_any;
    irq_enc_state_t    state_q;
    irq_enc_state_t    state_d;

    assign edge_v = bus.req & ~req_q;
    assign accept = (state_q == PRESENT) && bus.out_ready;
    // Only the presented source is cleared, and only on the accept edge.
    assign clear_v = accept ? (N_SRC'(1) << code_q) : '0;

`ifdef IRQ_ENC_MASK_EN
    assign cand = pending_q & bus.mask;
`else
    assign cand = pending_q;
`endif

    prio_enc8 u_prio (
        .vec (cand),
        .idx (win_idx),
        .any (win_any)
    );

    // Next-state logic. The winner is only sampled from IDLE, which is what
    // keeps a presented code stable against later higher-priority edges.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = PRESENT;
                    code_d  = win_idx;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            req_q     <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the
            // pre-edge values of the others (pending_q/code_q read below).
            state_q   <= state_d;
            code_q    <= code_d;
            req_q     <= bus.req;
            // Set is applied after clear so a same-cycle edge wins.
            pending_q <= (pending_q & ~clear_v) | edge_v;
            overrun_q <= |(edge_v & pending_q & ~clear_v);
        end
    end

    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_code  = code_q;
    assign bus.pending   = pending_q;
    assign bus.overrun   = overrun_q;

endmodule : irq_encoder8to3

// File: tb/tb_irq_encoder8to3.sv
// ---------------------------------------------------------------------------
// tb_irq_encoder8to3
// Self-checking bench for irq_encoder8to3: directed scenarios against fixed
// expectations plus a randomized run against a source-by-source reference
// model. Define IRQ_ENC_MASK_EN to exercise the mask feature as well.
// ---------------------------------------------------------------------------
module tb_irq_encoder8to3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    irq_encoder8to3_if bus ();

    irq_encoder8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: eight independent pending flags, the last req sample,
    // and the presented source (-1 style via m_valid).
    logic [7:0] m_pend;
    logic [7:0] m_prev;
    bit         m_valid;
    int         m_code;
    bit         m_ovr;

    function automatic bit selectable(int i);
`ifdef IRQ_ENC_MASK_EN
        return bus.mask[i] == 1'b1;
`else
        return i >= 0;
`endif
    endfunction

    task automatic model_reset();
        m_pend  = 8'h00;
        m_prev  = 8'h00;
        m_valid = 1'b0;
        m_code  = 0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step();
        int         acc;
        int         win;
        bit         rose;
        logic [7:0] nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc   = (m_valid && bus.out_ready) ? m_code : -1;
        m_ovr = 1'b0;
        nxt   = m_pend;
        for (int i = 0; i < 8; i++) begin
            rose = bus.req[i] && !m_prev[i];
            if (acc == i) nxt[i] = 1'b0;
            if (rose) begin
                if (m_pend[i] && acc != i) m_ovr = 1'b1;
                nxt[i] = 1'b1;
            end
        end
        if (m_valid) begin
            if (acc >= 0) m_valid = 1'b0;
        end else begin
            win = -1;
            for (int i = 7; i >= 0; i--) begin
                if (m_pend[i] && selectable(i)) win = i;
            end
            if (win >= 0) begin
                m_valid = 1'b1;
                m_code  = win;
            end
        end
        m_pend = nxt;
        m_prev = bus.req;
    endtask

    // One rising edge; returns 1 time unit later with the model updated.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        bus.req       = 8'h00;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        bus.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
`ifdef IRQ_ENC_MASK_EN
        bus.mask      = 8'hFF;
`endif
        model_reset();
        #2;
        repeat (3) tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h00 || bus.overrun !== 1'b0
            || bus.out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b pending=%h overrun=%b code=%0d want 0/00/0/0",
                     bus.out_valid, bus.pending, bus.overrun, bus.out_code);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b pending=%h want 0/00",
                     bus.out_valid, bus.pending);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.req       = 8'h20;
        tick();
        bus.req = 8'h00;
        n_tests++;
        if (bus.pending !== 8'h20 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pending: pending=%h valid=%b want 20/0", bus.pending, bus.out_valid);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd5) begin
            n_fail++;
            $display("FAIL single_present: valid=%b code=%0d want 1/5", bus.out_valid, bus.out_code);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_accept: valid=%b pending=%h want 0/00", bus.out_valid, bus.pending);
        end
        drain();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        bus.req       = 8'h84;
        tick();
        bus.req = 8'h00;
        n_tests++;
        if (bus.pending !== 8'h84) begin
            n_fail++;
            $display("FAIL stall_pending: pending=%h want 84", bus.pending);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b code=%0d want 1/2", c, bus.out_valid, bus.out_code);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h80) begin
            n_fail++;
            $display("FAIL stall_accept: valid=%b pending=%h want 0/80", bus.out_valid, bus.pending);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd7) begin
            n_fail++;
            $display("FAIL stall_next: valid=%b code=%0d want 1/7", bus.out_valid, bus.out_code);
        end
        drain();
    endtask

    task automatic test_preempt();
        bus.out_ready = 1'b0;
        bus.req       = 8'h08;
        tick();
        bus.req = 8'h00;
        tick();
        bus.req = 8'h01;
        tick();
        bus.req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd3 || bus.pending !== 8'h09) begin
                n_fail++;
                $display("FAIL preempt_hold[%0d]: valid=%b code=%0d pending=%h want 1/3/09",
                         c, bus.out_valid, bus.out_code, bus.pending);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL preempt_next: valid=%b code=%0d want 1/0", bus.out_valid, bus.out_code);
        end
        drain();
    endtask

    task automatic test_overrun();
        int ovr_cnt;
        int del_cnt;
        ovr_cnt       = 0;
        del_cnt       = 0;
        bus.out_ready = 1'b0;
        bus.req       = 8'h10;
        tick();
        ovr_cnt += int'(bus.overrun);
        bus.req = 8'h00;
        tick();
        ovr_cnt += int'(bus.overrun);
        bus.req = 8'h10;
        tick();
        ovr_cnt += int'(bus.overrun);
        bus.req = 8'h00;
        repeat (3) begin
            tick();
            ovr_cnt += int'(bus.overrun);
        end
        bus.out_ready = 1'b1;
        repeat (8) begin
            if (bus.out_valid === 1'b1 && bus.out_code === 3'd4) del_cnt++;
            tick();
            ovr_cnt += int'(bus.overrun);
        end
        n_tests++;
        if (ovr_cnt != 1) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt);
        end
        n_tests++;
        if (del_cnt != 1) begin
            n_fail++;
            $display("FAIL overrun_deliveries: got %0d want 1", del_cnt);
        end
        drain();
    endtask

    task automatic test_same_cycle_and_reset();
        bus.out_ready = 1'b0;
        bus.req       = 8'h40;
        tick();
        bus.req = 8'h00;
        tick();
        tick();
        bus.out_ready = 1'b1;
        bus.req       = 8'h40;
        tick();
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h40 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_set_wins: valid=%b pending=%h overrun=%b want 0/40/0",
                     bus.out_valid, bus.pending, bus.overrun);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd6) begin
            n_fail++;
            $display("FAIL same_cycle_represent: valid=%b code=%0d want 1/6", bus.out_valid, bus.out_code);
        end
        // Asynchronous reset in the middle of the handshake.
        bus.req = 8'h05;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h00 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_present: valid=%b pending=%h overrun=%b want 0/00/0",
                     bus.out_valid, bus.pending, bus.overrun);
        end
        bus.req = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_no_replay: valid=%b pending=%h want 0/00", bus.out_valid, bus.pending);
        end
    endtask

    task automatic test_held_through_reset();
        rst_n   = 1'b0;
        bus.req = 8'h02;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.pending !== 8'h02) begin
            n_fail++;
            $display("FAIL held_req_edge: pending=%h want 02", bus.pending);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd1) begin
            n_fail++;
            $display("FAIL held_req_present: valid=%b code=%0d want 1/1", bus.out_valid, bus.out_code);
        end
        drain();
    endtask

`ifdef IRQ_ENC_MASK_EN
    task automatic test_mask();
        bus.mask      = 8'hFE;
        bus.out_ready = 1'b1;
        bus.req       = 8'h01;
        tick();
        bus.req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bus.pending !== 8'h01 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mask_blocked[%0d]: pending=%h valid=%b want 01/0", c, bus.pending, bus.out_valid);
            end
            tick();
        end
        bus.mask      = 8'hFF;
        bus.out_ready = 1'b0;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL mask_unmask: valid=%b code=%0d want 1/0", bus.out_valid, bus.out_code);
        end
        bus.mask = 8'hFE;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL mask_in_present: valid=%b code=%0d want 1/0", bus.out_valid, bus.out_code);
        end
        bus.mask = 8'hFF;
        drain();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.req       = 8'($urandom) & 8'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef IRQ_ENC_MASK_EN
            bus.mask      = 8'($urandom) | 8'($urandom);
`endif
            tick();
            n_tests++;
            if (bus.out_valid !== m_valid || bus.pending !== m_pend || bus.overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL random[%0d]: valid=%b pending=%h overrun=%b want %b/%h/%b",
                         c, bus.out_valid, bus.pending, bus.overrun, m_valid, m_pend, m_ovr);
            end
            if (m_valid) begin
                n_tests++;
                if (bus.out_code !== 3'(m_code)) begin
                    n_fail++;
                    $display("FAIL random_code[%0d]: code=%0d want %0d", c, bus.out_code, m_code);
                end
            end
        end
`ifdef IRQ_ENC_MASK_EN
        bus.mask = 8'hFF;
`endif
        drain();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_stall();
        test_preempt();
        test_overrun();
        test_same_cycle_and_reset();
        test_held_through_reset();
`ifdef IRQ_ENC_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_irq_encoder8to3
